// File: rtl/exc_return_unit.sv
// exc_return_unit
// Return-side companion to the exception/interrupt redirect monitor. Every
// handler entry (Store_Current) pushes the interrupted PC and the mode that
// was in effect. A decoded RTI pops that context again. The unit then
// requests a jump back to the saved PC and hands the monitor a Mode_Set code
// that restores the saved privilege mode.
//
// The context stack is a circular buffer addressed by a write pointer.
// The top of the stack sits at wr_ptr-1. When the buffer is full, a push
// simply overwrites the slot holding the oldest entry, so an overflow
// discards the oldest context without any shifting.

module exc_return_unit #(
    parameter int DEPTH = 4,   // nested contexts held (power of 2, >= 2)
    parameter int PC_W  = 16   // PC width
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     Store_Current,
    input  logic [PC_W-1:0]          cur_PC,
    input  logic [1:0]               cur_Mode,
    input  logic                     rti,
    input  logic                     IFID_Stall,
    input  logic                     miss,
    output logic                     ret_J,
    output logic [PC_W-1:0]          ret_PC,
    output logic [1:0]               ret_Mode_Set,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     overflow,
    output logic                     underflow
);

    // Width of a stack slot index. The depth counter is one bit wider so
    // that it can hold DEPTH itself.
    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0]   DEPTH_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   DEPTH_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   DEPTH_ZERO = '0;
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    // Mode_Set codes understood by the monitor.
    localparam logic [1:0] MSET_NONE = 2'b00;  // no change / back to mode 0
    localparam logic [1:0] MSET_USER = 2'b01;  // restores saved mode 2'b00
    localparam logic [1:0] MSET_SUP  = 2'b10;  // restores saved mode 2'b01

    typedef enum logic {
        IDLE = 1'b0,
        RET  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            state_q, state_d;

    logic [PC_W-1:0]   stack_pc_q   [DEPTH];
    logic [PC_W-1:0]   stack_pc_d   [DEPTH];
    logic [1:0]        stack_mode_q [DEPTH];
    logic [1:0]        stack_mode_d [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]       depth_q, depth_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic              push;
    logic              pop;
    logic              rti_accept;
    logic              stack_full;
    logic              stack_empty;
    logic [AW-1:0]     top_idx;
    logic [PC_W-1:0]   top_pc;
    logic [1:0]        top_mode;

    assign push        = Store_Current;
    assign stack_full  = (depth_q == DEPTH_FULL);
    assign stack_empty = (depth_q == DEPTH_ZERO);
    assign top_idx     = wr_ptr_q - PTR_ONE;
    assign top_pc      = stack_pc_q[top_idx];
    assign top_mode    = stack_mode_q[top_idx];

    // Store_Current outranks rti: the monitor is already redirecting, so the
    // rti in ID is dead and must not be accepted.
    assign rti_accept  = (state_q == IDLE) && rti && !IFID_Stall && !miss
                         && !Store_Current;

    // The return retires only on a cycle with no stall, squash, or push.
    // This also guarantees that a push and a pop never coincide.
    assign pop         = (state_q == RET) && !Store_Current && !miss
                         && !IFID_Stall;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every flop samples the values from before the clock edge.
            state_q <= state_d;
        end
    end

    // Next-state logic: enter RET on an accepted rti with context available;
    // leave RET when the return is squashed, aborted, or retired.
    always_comb begin
        // NOTE: default first, so every path assigns and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (rti_accept && !stack_empty) begin
                    state_d = RET;
                end
            end
            RET: begin
                if (Store_Current || miss) begin
                    state_d = IDLE;
                end else if (IFID_Stall) begin
                    state_d = RET;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: the return request comes only from the registered state
    // and the stack top, so there is no combinational path from rti.
    always_comb begin
        ret_J        = 1'b0;
        ret_PC       = '0;
        ret_Mode_Set = MSET_NONE;
        if (state_q == RET) begin
            ret_J  = 1'b1;
            ret_PC = top_pc;
            unique casez (top_mode)
                2'b00:   ret_Mode_Set = MSET_USER;
                2'b01:   ret_Mode_Set = MSET_SUP;
                2'b1?:   ret_Mode_Set = MSET_NONE;
                default: ret_Mode_Set = MSET_NONE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Context stack
    // ------------------------------------------------------------------

    // Stack next-state: write on a push, move the pointer and depth on a push
    // or pop, and record sticky overflow/underflow events.
    always_comb begin
        stack_pc_d   = stack_pc_q;
        stack_mode_d = stack_mode_q;
        wr_ptr_d     = wr_ptr_q;
        depth_d      = depth_q;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;

        if (push) begin
            // When full, wr_ptr_q points at the oldest entry, so this write
            // discards it and the depth stays saturated.
            stack_pc_d[wr_ptr_q]   = cur_PC;
            stack_mode_d[wr_ptr_q] = cur_Mode;
            wr_ptr_d               = wr_ptr_q + PTR_ONE;
            if (stack_full) begin
                overflow_d = 1'b1;
            end else begin
                depth_d = depth_q + DEPTH_ONE;
            end
        end else if (pop) begin
            wr_ptr_d = wr_ptr_q - PTR_ONE;
            depth_d  = depth_q - DEPTH_ONE;
        end

        if (rti_accept && stack_empty) begin
            underflow_d = 1'b1;
        end
    end

    // Stack registers: the pointer, depth, flags, and all entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            // NOTE: the stack entries are reset on purpose. The storage is
            // small, and a reset must leave no stale context to return to.
            for (int i = 0; i < DEPTH; i++) begin
                stack_pc_q[i]   <= '0;
                stack_mode_q[i] <= 2'b00;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            depth_q     <= depth_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            for (int i = 0; i < DEPTH; i++) begin
                stack_pc_q[i]   <= stack_pc_d[i];
                stack_mode_q[i] <= stack_mode_d[i];
            end
        end
    end

    assign depth     = depth_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_exc_return_unit.sv
// Directed bench for exc_return_unit (DEPTH=4, PC_W=16).
// Inputs are driven and outputs are checked on the falling edge of clk.
module tb_exc_return_unit;

    logic        clk;
    logic        rst;
    logic        Store_Current;
    logic [15:0] cur_PC;
    logic [1:0]  cur_Mode;
    logic        rti;
    logic        IFID_Stall;
    logic        miss;
    logic        ret_J;
    logic [15:0] ret_PC;
    logic [1:0]  ret_Mode_Set;
    logic [2:0]  depth;
    logic        overflow;
    logic        underflow;

    int n_vec  = 0;
    int n_miss = 0;

    exc_return_unit #(.DEPTH(4), .PC_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .Store_Current(Store_Current),
        .cur_PC       (cur_PC),
        .cur_Mode     (cur_Mode),
        .rti          (rti),
        .IFID_Stall   (IFID_Stall),
        .miss         (miss),
        .ret_J        (ret_J),
        .ret_PC       (ret_PC),
        .ret_Mode_Set (ret_Mode_Set),
        .depth        (depth),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, clock them in, and return at the next falling
    // edge with the inputs cleared.
    task automatic step(input logic sc, input logic [15:0] pc, input logic [1:0] md,
                        input logic r, input logic st, input logic ms);
        Store_Current = sc;
        cur_PC        = pc;
        cur_Mode      = md;
        rti           = r;
        IFID_Stall    = st;
        miss          = ms;
        @(posedge clk);
        @(negedge clk);
        Store_Current = 1'b0;
        cur_PC        = '0;
        cur_Mode      = 2'b00;
        rti           = 1'b0;
        IFID_Stall    = 1'b0;
        miss          = 1'b0;
    endtask

    task automatic push(input logic [15:0] pc, input logic [1:0] md);
        step(1'b1, pc, md, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_rti();
        step(1'b0, 16'h0, 2'b00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_ret(input string tag, input logic [15:0] pc, input logic [1:0] mset);
        check({tag, ".ret_J"}, 32'(ret_J), 1);
        check({tag, ".ret_PC"}, 32'(ret_PC), 32'(pc));
        check({tag, ".mset"}, 32'(ret_Mode_Set), 32'(mset));
    endtask

    initial begin
        rst = 1'b1;
        Store_Current = 1'b0; cur_PC = '0; cur_Mode = 2'b00;
        rti = 1'b0; IFID_Stall = 1'b0; miss = 1'b0;
        repeat (2) @(negedge clk);

        // The reset state.
        check("rst.ret_J", 32'(ret_J), 0);
        check("rst.ret_PC", 32'(ret_PC), 0);
        check("rst.mset", 32'(ret_Mode_Set), 0);
        check("rst.depth", 32'(depth), 0);
        check("rst.ovf", 32'(overflow), 0);
        check("rst.unf", 32'(underflow), 0);
        rst = 1'b0;
        idle();

        // A single push followed by a return.
        push(16'h1234, 2'b00);
        check("t1.depth_push", 32'(depth), 1);
        check("t1.noJ", 32'(ret_J), 0);
        do_rti();
        check_ret("t1", 16'h1234, 2'b01);
        idle();
        check("t1.J_off", 32'(ret_J), 0);
        check("t1.pc_off", 32'(ret_PC), 0);
        check("t1.depth_pop", 32'(depth), 0);

        // An rti that is stalled or squashed while the stack is empty is not accepted.
        step(1'b0, 16'h0, 2'b00, 1'b1, 1'b1, 1'b0);
        check("nacc.stall_unf", 32'(underflow), 0);
        step(1'b0, 16'h0, 2'b00, 1'b1, 1'b0, 1'b1);
        check("nacc.miss_unf", 32'(underflow), 0);
        check("nacc.J", 32'(ret_J), 0);

        // Nested contexts return in LIFO order.
        push(16'h0100, 2'b01);
        push(16'h0200, 2'b00);
        check("t2.depth", 32'(depth), 2);
        do_rti();
        check_ret("t2a", 16'h0200, 2'b01);
        idle();
        check("t2a.depth", 32'(depth), 1);
        do_rti();
        check_ret("t2b", 16'h0100, 2'b10);
        idle();
        check("t2b.depth", 32'(depth), 0);

        // A stall during RET holds the outputs and pops only once.
        push(16'h0ABC, 2'b10);
        do_rti();
        check_ret("t3.c0", 16'h0ABC, 2'b00);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h0, 2'b00, 1'b0, 1'b1, 1'b0);
            check_ret("t3.stall", 16'h0ABC, 2'b00);
            check("t3.stall_depth", 32'(depth), 1);
        end
        idle();
        check("t3.J_off", 32'(ret_J), 0);
        check("t3.depth", 32'(depth), 0);

        // A miss in the RET cycle squashes the return without a pop.
        push(16'h0D00, 2'b00);
        do_rti();
        check_ret("t4m", 16'h0D00, 2'b01);
        step(1'b0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b1);
        check("t4m.J_off", 32'(ret_J), 0);
        check("t4m.depth", 32'(depth), 1);

        // Store_Current in the RET cycle aborts the return and pushes.
        do_rti();
        check_ret("t4s", 16'h0D00, 2'b01);
        push(16'h0E00, 2'b01);
        check("t4s.J_off", 32'(ret_J), 0);
        check("t4s.depth", 32'(depth), 2);
        do_rti();
        check_ret("t4s.top", 16'h0E00, 2'b10);
        idle();
        do_rti();
        check_ret("t4s.next", 16'h0D00, 2'b01);
        idle();
        check("t4s.depth_end", 32'(depth), 0);

        // When Store_Current and rti arrive in the same cycle, the push wins and the rti is dropped.
        step(1'b1, 16'h0F00, 2'b11, 1'b1, 1'b0, 1'b0);
        check("t4p.J", 32'(ret_J), 0);
        check("t4p.depth", 32'(depth), 1);
        check("t4p.unf", 32'(underflow), 0);
        do_rti();
        check_ret("t4p.ret", 16'h0F00, 2'b00);
        idle();

        // Overflow discards the oldest entry; a fifth rti underflows.
        for (int i = 1; i <= 5; i++) begin
            push(16'(i), 2'b00);
            if (i == 4) check("t5.ovf_at_full", 32'(overflow), 0);
        end
        check("t5.ovf", 32'(overflow), 1);
        check("t5.depth", 32'(depth), 4);
        for (int i = 5; i >= 2; i--) begin
            do_rti();
            check_ret("t5.pop", 16'(i), 2'b01);
            idle();
        end
        check("t5.depth_empty", 32'(depth), 0);
        do_rti();
        check("t5.unf", 32'(underflow), 1);
        check("t5.unf_noJ", 32'(ret_J), 0);
        check("t5.ovf_sticky", 32'(overflow), 1);

        // An asynchronous reset in the middle of RET takes effect without a clock edge.
        push(16'h7777, 2'b01);
        do_rti();
        check_ret("t6.pre", 16'h7777, 2'b10);
        #2 rst = 1'b1;
        #1;
        check("t6.J", 32'(ret_J), 0);
        check("t6.pc", 32'(ret_PC), 0);
        check("t6.depth", 32'(depth), 0);
        check("t6.ovf", 32'(overflow), 0);
        check("t6.unf", 32'(underflow), 0);
        @(negedge clk);
        rst = 1'b0;
        do_rti();
        check("t6.post_unf", 32'(underflow), 1);
        check("t6.post_J", 32'(ret_J), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
